// File: rtl/fir_out_formatter.sv
// rtl/fir_out_formatter.sv - FIR output decimator, scaler/saturator and FWFT output FIFO
// Optional rounding is enabled by defining FIR_OUT_ROUND_EN (round half toward +infinity);
// without it the scaling is a plain arithmetic shift.
module fir_out_formatter #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 6,
  parameter int DECIM      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic signed [IN_W-1:0]        in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sat_seen,
  output logic                          overflow
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int XW   = IN_W + 1;

  // Clamp bounds expressed at the widened intermediate width so no wrap can occur
  localparam logic signed [XW-1:0] MAX_V = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [XW-1:0] MIN_V = {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [PH_W-1:0]         phase;
  logic                    keep;
  logic signed [XW-1:0]    ext;
  logic signed [XW-1:0]    biased;
  logic signed [XW-1:0]    shifted;
  logic                    sat_hi;
  logic                    sat_lo;
  logic [OUT_W-1:0]        clamped;

  logic                    s1_valid;
  logic [OUT_W-1:0]        s1_data;

  logic [OUT_W-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [LW-1:0]           level;
  logic [OUT_W-1:0]        last_data;
  logic                    full;
  logic                    pop;
  logic                    push;

  assign keep = in_valid && (phase == '0);

  // Decimation phase: advances only on valid samples, wraps at DECIM-1
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
    end else if (in_valid) begin
      if (phase == PH_W'(DECIM - 1)) phase <= '0;
      else                           phase <= phase + 1'b1;
    end
  end

  // Widen, optionally round, shift and clamp the incoming sample
  always_comb begin
    ext = {in_data[IN_W-1], in_data};
`ifdef FIR_OUT_ROUND_EN
    biased = ext + (XW'(1) << (SHIFT - 1));
`else
    biased = ext;
`endif
    shifted = biased >>> SHIFT;
    sat_hi  = (shifted > MAX_V);
    sat_lo  = (shifted < MIN_V);
    if (sat_hi)      clamped = {1'b0, {(OUT_W-1){1'b1}}};
    else if (sat_lo) clamped = {1'b1, {(OUT_W-1){1'b0}}};
    else             clamped = shifted[OUT_W-1:0];
  end

  // Stage-1 register plus sticky saturation flag, set as the clamped value loads
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      sat_seen <= 1'b0;
    end else begin
      s1_valid <= keep;
      if (keep) begin
        s1_data <= clamped;
        if (sat_hi || sat_lo) sat_seen <= 1'b1;
      end
    end
  end

  assign full      = (level == LW'(FIFO_DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  // A pop frees the slot this cycle, so a push is accepted even when full
  assign push      = s1_valid && (!full || pop);

  // FIFO storage; the write may target the slot being popped, which is read before the edge
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s1_data;
  end

  // FIFO pointers, occupancy, last popped value and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      last_data <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_data <= mem[rd_ptr];
      end
      if (push && !pop)      level <= level + 1'b1;
      else if (!push && pop) level <= level - 1'b1;
      if (s1_valid && full && !pop) overflow <= 1'b1;
    end
  end

  // Head is presented directly; when empty the last consumed value is held
  assign out_data   = out_valid ? mem[rd_ptr] : last_data;
  assign fifo_level = level;

endmodule

// File: tb/tb_fir_out_formatter.sv
// tb/tb_fir_out_formatter.sv - randomized self-checking bench for fir_out_formatter
module tb_fir_out_formatter;

  localparam int SHIFT = 6;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        ov0, ov1;
  logic [15:0] od0, od1;
  logic [2:0]  lv0, lv1;
  logic        sat0, sat1, of0, of1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fir_out_formatter #(.IN_W(32), .OUT_W(16), .SHIFT(SHIFT), .DECIM(1), .FIFO_DEPTH(DEPTH)) dut_d1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .fifo_level(lv0), .sat_seen(sat0), .overflow(of0)
  );

  fir_out_formatter #(.IN_W(32), .OUT_W(16), .SHIFT(SHIFT), .DECIM(2), .FIFO_DEPTH(DEPTH)) dut_d2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .fifo_level(lv1), .sat_seen(sat1), .overflow(of1)
  );

  // Reference model state, one set per instance (0: DECIM=1, 1: DECIM=2)
  int cnt[2];
  bit s1v[2];
  int s1d[2];
  int last[2];
  bit msat[2];
  bit movf[2];
  int q0[$];
  int q1[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qhead(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  // Floor division by 2^SHIFT (optionally after adding half an LSB), then clamp
  function automatic int scale(input int x, output bit sat);
    longint v;
    longint q;
    longint div;
    div = longint'(1) << SHIFT;
    v = longint'(x);
`ifdef FIR_OUT_ROUND_EN
    v = v + div / 2;
`endif
    q = (v >= 0) ? v / div : -((-v + div - 1) / div);
    sat = 1'b0;
    if (q > 32767)  begin q = 32767;  sat = 1'b1; end
    if (q < -32768) begin q = -32768; sat = 1'b1; end
    return int'(q);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; s1v[k] = 0; s1d[k] = 0; last[k] = 0; msat[k] = 0; movf[k] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step(input int k, input int d);
    bit full;
    bit pop;
    bit s;
    int v;
    full = (qsize(k) == DEPTH);
    pop  = (qsize(k) != 0) && out_ready;
    if (pop) begin
      last[k] = qhead(k);
      if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    if (s1v[k]) begin
      if (full && !pop) movf[k] = 1'b1;
      else if (k == 0) q0.push_back(s1d[k]);
      else             q1.push_back(s1d[k]);
    end
    s1v[k] = 1'b0;
    if (in_valid) begin
      if (cnt[k] % d == 0) begin
        v = scale(int'(in_data), s);
        s1v[k] = 1'b1;
        s1d[k] = v;
        if (s) msat[k] = 1'b1;
      end
      cnt[k]++;
    end
  endtask

  task automatic compare_outputs();
    int ev;
    ev = (qsize(0) != 0) ? qhead(0) : last[0];
    check("d1_valid", int'(ov0), int'(qsize(0) != 0));
    check("d1_data", int'($signed(od0)), ev);
    check("d1_level", int'(lv0), qsize(0));
    check("d1_sat", int'(sat0), int'(msat[0]));
    check("d1_ovf", int'(of0), int'(movf[0]));
    ev = (qsize(1) != 0) ? qhead(1) : last[1];
    check("d2_valid", int'(ov1), int'(qsize(1) != 0));
    check("d2_data", int'($signed(od1)), ev);
    check("d2_level", int'(lv1), qsize(1));
    check("d2_sat", int'(sat1), int'(msat[1]));
    check("d2_ovf", int'(of1), int'(movf[1]));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_outputs();
    if (reset) model_reset();
    else begin
      model_step(0, 1);
      model_step(1, 2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int data, input bit rdy);
    in_valid  = v;
    in_data   = data;
    out_ready = rdy;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b1, 12345, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    do_reset();

    // Rounding and latency
    drive(1, 100, 1);
    drive(1, -100, 1);
    repeat (4) drive(0, 0, 1);

    // Saturation at both rails, then in-range samples keep sat_seen high
    drive(1, 32'h7FFF_FFFF, 1);
    drive(1, 32'h8000_0000, 1);
    drive(1, 100, 1);
    drive(1, 200, 1);
    repeat (4) drive(0, 0, 1);
    check("sat_sticky_d1", int'(sat0), 1);
    check("sat_sticky_d2", int'(sat1), 1);

    // Decimation with idle gaps
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 64 * i, 1);
      drive(0, 0, 1);
      drive(0, 0, 1);
    end
    repeat (3) drive(0, 0, 1);

    // FIFO full and drop, then drain
    do_reset();
    for (int i = 1; i <= 6; i++) drive(1, 64 * i, 0);
    repeat (3) drive(0, 0, 0);
    check("full_level", int'(lv0), DEPTH);
    check("full_ovf", int'(of0), 1);
    repeat (8) drive(0, 0, 1);
    check("drained_level", int'(lv0), 0);
    check("drained_valid", int'(ov0), 0);

    // Push and pop on the same cycle while full
    do_reset();
    for (int i = 1; i <= 4; i++) drive(1, 64 * i, 0);
    drive(1, 320, 0);
    drive(0, 0, 1);
    check("pushpop_level", int'(lv0), DEPTH);
    check("pushpop_ovf", int'(of0), 0);
    repeat (7) drive(0, 0, 1);

    // Reset mid-stream with data buffered and a sample in stage 1, odd phase left behind
    do_reset();
    for (int i = 1; i <= 3; i++) drive(1, 640 * i, 0);
    drive(1, 32'h7FFF_FFFF, 0);
    do_reset();
    check("rst_level", int'(lv0), 0);
    check("rst_valid", int'(ov1), 0);
    drive(1, 4096, 1);
    repeat (3) drive(0, 0, 1);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      int data;
      case ($urandom_range(0, 3))
        0:       data = int'($urandom());
        1:       data = int'($urandom_range(0, 4095)) - 2048;
        default: data = int'($urandom_range(0, 32'h0040_0000)) - 32'h0020_0000;
      endcase
      reset = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 3) != 0, data, $urandom_range(0, 2) != 0);
      reset = 1'b0;
    end
    repeat (8) drive(0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_out_formatter.md
Name: fir_out_formatter

Overview:
- Sits directly downstream of the 8-tap FIR filter.
- Takes the filter's 32-bit signed accumulator stream, decimates it and scales it back to 16 bits with saturation.
- Buffers results in a small FIFO and presents them on a valid/ready interface to the next consumer (DMA/serializer).
- Gives the filter path backpressure tolerance, since the filter itself cannot be stalled.

Parameters:
- IN_W, 32, input sample width (signed).
- OUT_W, 16, output sample width (signed).
- SHIFT, 6, arithmetic right shift applied before saturation (1..IN_W-1).
- DECIM, 2, keep 1 of every DECIM input samples (1..16; 1 = no decimation).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  sample strobe: filter input strobe registered one cycle, aligned to in_data.
- in_data  in  IN_W  signed filter output sample.
- out_valid  out  1  FIFO head holds a valid sample.
- out_ready  in  1  consumer accepts head this cycle.
- out_data  out  OUT_W  signed FIFO head (first-word-fall-through).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- sat_seen  out  1  sticky: at least one sample saturated.
- overflow  out  1  sticky: at least one kept sample dropped because FIFO was full.

Behaviour:
- Interface and reset: clock clk, reset reset (synchronous, active-high). Reset clears the phase counter, the stage-1 register, the FIFO pointers and level, and both sticky flags. Outputs after reset: out_valid=0, out_data=0, fifo_level=0, sat_seen=0, overflow=0.
- Reset mid-operation: discards all buffered and in-flight samples. No output appears for inputs presented during the reset cycle.
- Decimation:
  - Phase counter 0..DECIM-1, advanced only on in_valid, wraps to 0.
  - A sample is kept when in_valid=1 and phase=0, so the first sample after reset is kept.
  - in_valid=0 cycles never advance the phase.
- Stage 1 (registered, 1 cycle), for each kept sample:
  - Sign-extend to IN_W+1 bits.
  - Optionally add the rounding constant (see Optional Feature).
  - Arithmetic shift right by SHIFT.
  - Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - On clamp, set sat_seen on the cycle the stage-1 register loads.
  - Intermediate width is IN_W+1; no wrap-around is permitted anywhere.
- Stage 2 (FIFO push):
  - A valid stage-1 result pushes into the FIFO.
  - Full and no pop this cycle: sample is dropped, FIFO unchanged, overflow set.
  - Full and pop this cycle: push accepted, level stays FIFO_DEPTH, no drop.
  - Empty: push and pop cannot coincide, since out_valid=0.
- Output:
  - out_valid = (level != 0).
  - out_data = head entry; must not change while out_valid=1 and out_ready=0.
  - Pop occurs when out_valid & out_ready.
  - out_data holds its last value when the FIFO is empty.
- Latency: kept in_valid at cycle N -> stage 1 at N+1 -> out_valid=1 at N+2 when the FIFO was empty.
- Throughput: one kept sample per cycle (DECIM=1, in_valid every cycle) sustained when out_ready=1.
- FIFO wrap: pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Level tracks push-minus-pop.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: FIR_OUT_ROUND_EN.
- Defined: add 2^(SHIFT-1) before the shift (round half toward +infinity).
- Undefined: plain arithmetic shift (floor/truncate toward -infinity). No adder is generated.
- Saturation, latency and all other behaviour are identical in both builds.

Test Plan:
- Rounding: DECIM=1, SHIFT=6, in_data=100 then -100, out_ready=1 -> with FIR_OUT_ROUND_EN out_data 2 then -2; without it 1 then -2. out_valid rises 2 cycles after the first in_valid.
- Saturation: in_data=32'h7FFFFFFF then 32'h80000000 -> out_data 32767 then -32768, sat_seen=1 and stays 1 through later in-range samples.
- Decimation: DECIM=2, rounding on, in_data 64,128,192,256 on consecutive in_valid with idle cycles between them -> exactly two outputs, 1 then 3. Idle cycles do not shift the phase.
- FIFO full/drop: out_ready=0, DECIM=1, 6 in_valid samples 64,128..384 -> fifo_level=4, overflow=1. Then raising out_ready drains 1,2,3,4 in order, level returns to 0, out_valid=0.
- Simultaneous push/pop at full: FIFO full, out_ready=1 on the same cycle a new sample lands -> level stays 4, overflow stays 0, the new sample appears after the existing four.
- Reset mid-stream: reset asserted with 3 entries buffered and a sample in stage 1 -> next cycle out_valid=0, fifo_level=0, flags 0. The first post-reset sample is kept regardless of the prior phase.
